// File: rtl/adsr.sv
// adsr: fixed-point ADSR envelope generator; define ADSR_HARD_RETRIGGER_EN to restart attack from 0 on retrigger
module adsr #(
  parameter int TOTAL_BITS      = 16,
  parameter int FRACTIONAL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  gate,
  input  logic [TOTAL_BITS-1:0] attack_step,
  input  logic [TOTAL_BITS-1:0] decay_step,
  input  logic [TOTAL_BITS-1:0] sustain_level,
  input  logic [TOTAL_BITS-1:0] release_step,
  output logic [TOTAL_BITS-1:0] out,
  output logic [2:0]            stage,
  output logic                  busy
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;
  localparam logic [TOTAL_BITS-1:0] ONE = TOTAL_BITS'(1) << FRACTIONAL_BITS;
  state_t                r_stage, w_next_stage, w_att_stage, w_rel_stage;
  logic [TOTAL_BITS-1:0] r_out, w_next_out, w_att_out, w_rel_out, w_sus, w_base;
  logic [TOTAL_BITS:0]   w_sum, w_dec, w_rel;
  logic                  r_gate, w_gate, w_att_done, w_dec_done, w_rel_done;
  // next level/stage; the extra top bit of each step result is the carry/borrow
  always_comb begin
    w_gate = sample_tick ? gate : r_gate;
    w_sus  = (sustain_level > ONE) ? ONE : sustain_level;
`ifdef ADSR_HARD_RETRIGGER_EN
    w_base = (r_stage == RELEASE) ? '0 : r_out;
`else
    w_base = r_out;
`endif
    w_sum       = {1'b0, w_base} + {1'b0, attack_step};
    w_dec       = {1'b0, r_out} - {1'b0, decay_step};
    w_rel       = {1'b0, r_out} - {1'b0, release_step};
    w_att_done  = (w_sum >= {1'b0, ONE}) || (attack_step == '0);
    w_dec_done  = w_dec[TOTAL_BITS] || (w_dec[TOTAL_BITS-1:0] <= w_sus) || (decay_step == '0);
    w_rel_done  = w_rel[TOTAL_BITS] || (w_rel[TOTAL_BITS-1:0] == '0) || (release_step == '0);
    w_att_stage = w_att_done ? DECAY : ATTACK;
    w_att_out   = w_att_done ? ONE : w_sum[TOTAL_BITS-1:0];
    w_rel_stage = w_rel_done ? IDLE : RELEASE;
    w_rel_out   = w_rel_done ? '0 : w_rel[TOTAL_BITS-1:0];
    w_next_stage = IDLE;
    w_next_out   = '0;
    case (r_stage)
      IDLE: begin
        w_next_stage = w_gate ? w_att_stage : IDLE;
        w_next_out   = w_gate ? w_att_out : '0;
      end
      ATTACK, RELEASE: begin
        w_next_stage = w_gate ? w_att_stage : w_rel_stage;
        w_next_out   = w_gate ? w_att_out : w_rel_out;
      end
      DECAY: begin
        w_next_stage = !w_gate ? w_rel_stage : w_dec_done ? SUSTAIN : DECAY;
        w_next_out   = !w_gate ? w_rel_out : w_dec_done ? w_sus : w_dec[TOTAL_BITS-1:0];
      end
      SUSTAIN: begin
        w_next_stage = w_gate ? SUSTAIN : w_rel_stage;
        w_next_out   = w_gate ? w_sus : w_rel_out;
      end
      default: begin
        w_next_stage = IDLE;
        w_next_out   = '0;
      end
    endcase
  end
  // envelope state advances only on sample ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= IDLE;
      r_out   <= '0;
      r_gate  <= 1'b0;
    end else if (sample_tick) begin
      r_stage <= w_next_stage;
      r_out   <= w_next_out;
      r_gate  <= gate;
    end
  end
  assign out   = r_out;
  assign stage = r_stage;
  assign busy  = (r_stage != IDLE);
endmodule

// File: tb/tb_adsr.sv
// tb_adsr: directed spec scenarios plus randomized run against an arithmetic envelope model
module tb_adsr;
  localparam int ONE = 256;
`ifdef ADSR_HARD_RETRIGGER_EN
  localparam bit HARD = 1'b1;
`else
  localparam bit HARD = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] att = '0, dec = '0, sus = '0, rel = '0;
  logic [15:0] out;
  logic [2:0]  stage;
  logic        busy;
  int          tests = 0;
  int          fails = 0;
  int          m_lvl = 0;
  int          m_st = 0;
  adsr #(.TOTAL_BITS(16), .FRACTIONAL_BITS(8)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .gate(gate),
    .attack_step(att), .decay_step(dec), .sustain_level(sus), .release_step(rel),
    .out(out), .stage(stage), .busy(busy)
  );
  always #5 clk = ~clk;
  // reference envelope: stages as small ints, levels as plain integers
  task automatic model_tick(input bit g);
    int s, nl;
    s = (int'(sus) > ONE) ? ONE : int'(sus);
    if (m_st > 4) begin
      m_st = 0; m_lvl = 0;
    end else if (!g && m_st != 0) begin
      nl = m_lvl - int'(rel);
      if (nl <= 0 || rel == 0) begin m_st = 0; m_lvl = 0; end
      else begin m_st = 4; m_lvl = nl; end
    end else if (g && (m_st == 0 || m_st == 1 || m_st == 4)) begin
      nl = ((HARD && m_st == 4) ? 0 : m_lvl) + int'(att);
      if (nl >= ONE || att == 0) begin m_st = 2; m_lvl = ONE; end
      else begin m_st = 1; m_lvl = nl; end
    end else if (m_st == 2) begin
      nl = m_lvl - int'(dec);
      if (nl <= s || dec == 0) begin m_st = 3; m_lvl = s; end
      else m_lvl = nl;
    end else if (m_st == 3) begin
      m_lvl = s;
    end else begin
      m_lvl = 0;
    end
  endtask
  task automatic do_tick(input bit g, input bit t);
    @(negedge clk);
    gate = g;
    sample_tick = t;
    @(posedge clk);
    if (t) model_tick(g);
    #1 sample_tick = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_st = 0; m_lvl = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests += 3;
    if (out !== 16'h0) begin fails++; $display("FAIL reset_out got %h want 0000", out); end
    if (stage !== 3'd0) begin fails++; $display("FAIL reset_stage got %0d want 0", stage); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_adsr_ramp();
    logic [15:0] eo [8] = '{16'h40, 16'h80, 16'hC0, 16'h100, 16'hE0, 16'hC0, 16'hA0, 16'h80};
    logic [2:0]  es [8] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [15:0] ro [3] = '{16'h50, 16'h20, 16'h00};
    logic [2:0]  rs [3] = '{3'd4, 3'd4, 3'd0};
    do_reset();
    att = 16'h40; dec = 16'h20; sus = 16'h80; rel = 16'h30;
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b1, 1'b1);
      tests += 3;
      if (out !== eo[i]) begin fails++; $display("FAIL ramp_out[%0d] got %h want %h", i, out, eo[i]); end
      if (stage !== es[i]) begin fails++; $display("FAIL ramp_stage[%0d] got %0d want %0d", i, stage, es[i]); end
      if (busy !== 1'b1) begin fails++; $display("FAIL ramp_busy[%0d] got %b want 1", i, busy); end
    end
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 1'b1);
      tests += 3;
      if (out !== ro[i]) begin fails++; $display("FAIL release_out[%0d] got %h want %h", i, out, ro[i]); end
      if (stage !== rs[i]) begin fails++; $display("FAIL release_stage[%0d] got %0d want %0d", i, stage, rs[i]); end
      if (busy !== (i < 2)) begin fails++; $display("FAIL release_busy[%0d] got %b want %b", i, busy, i < 2); end
    end
  endtask
  task automatic test_hold();
    do_reset();
    att = 16'h30; dec = 16'h10; sus = 16'h80; rel = 16'h10;
    do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b0);
    do_tick(1'b0, 1'b1);
    tests += 2;
    if (out !== 16'h0) begin fails++; $display("FAIL pulse_ignored_out got %h want 0000", out); end
    if (stage !== 3'd0) begin fails++; $display("FAIL pulse_ignored_stage got %0d want 0", stage); end
    do_tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_tick(i[0], 1'b0);
      tests += 2;
      if (out !== 16'h30) begin fails++; $display("FAIL hold_out[%0d] got %h want 0030", i, out); end
      if (stage !== 3'd1) begin fails++; $display("FAIL hold_stage[%0d] got %0d want 1", i, stage); end
    end
  endtask
  task automatic test_zero_attack();
    logic [2:0] es [3] = '{3'd2, 3'd3, 3'd3};
    do_reset();
    att = 16'h0; dec = 16'h20; sus = 16'h200; rel = 16'h0;
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 1'b1);
      tests += 2;
      if (out !== 16'h100) begin fails++; $display("FAIL zero_att_out[%0d] got %h want 0100", i, out); end
      if (stage !== es[i]) begin fails++; $display("FAIL zero_att_stage[%0d] got %0d want %0d", i, stage, es[i]); end
    end
    do_tick(1'b0, 1'b1);
    tests += 2;
    if (out !== 16'h0) begin fails++; $display("FAIL zero_rel_out got %h want 0000", out); end
    if (stage !== 3'd0) begin fails++; $display("FAIL zero_rel_stage got %0d want 0", stage); end
  endtask
  task automatic test_retrigger();
    logic [15:0] want;
    want = HARD ? 16'h40 : 16'h90;
    do_reset();
    att = 16'h40; dec = 16'h20; sus = 16'h80; rel = 16'h30;
    for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b1);
    do_tick(1'b0, 1'b1);
    tests++;
    if (out !== 16'h50) begin fails++; $display("FAIL retrig_pre got %h want 0050", out); end
    do_tick(1'b1, 1'b1);
    tests += 2;
    if (out !== want) begin fails++; $display("FAIL retrig_out got %h want %h", out, want); end
    if (stage !== 3'd1) begin fails++; $display("FAIL retrig_stage got %0d want 1", stage); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    att = 16'h40; dec = 16'h20; sus = 16'h80; rel = 16'h30;
    do_tick(1'b1, 1'b1);
    do_tick(1'b1, 1'b1);
    tests++;
    if (out !== 16'h80) begin fails++; $display("FAIL mid_pre got %h want 0080", out); end
    #2 reset = 1'b1;
    #1;
    tests += 2;
    if (out !== 16'h0) begin fails++; $display("FAIL mid_reset_out got %h want 0000", out); end
    if (stage !== 3'd0) begin fails++; $display("FAIL mid_reset_stage got %0d want 0", stage); end
    @(negedge clk);
    reset = 1'b0;
    m_st = 0; m_lvl = 0;
    for (int i = 0; i < 10; i++) begin
      do_tick(1'b1, 1'b0);
      tests++;
      if (out !== 16'h0 || stage !== 3'd0) begin
        fails++; $display("FAIL mid_notick[%0d] got %h/%0d want 0000/0", i, out, stage);
      end
    end
    do_tick(1'b1, 1'b1);
    tests++;
    if (out !== 16'h40 || stage !== 3'd1) begin
      fails++; $display("FAIL mid_restart got %h/%0d want 0040/1", out, stage);
    end
  endtask
  function automatic logic [15:0] rnd_step();
    int k;
    k = $urandom_range(0, 9);
    return (k == 0) ? 16'h0 : (k == 1) ? 16'($urandom_range(16'h100, 16'hFFFF)) : 16'($urandom_range(1, 16'h60));
  endfunction
  task automatic test_random();
    bit g, t;
    g = 1'b0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        att = rnd_step(); dec = rnd_step(); rel = rnd_step();
        sus = 16'($urandom_range(0, 16'h180));
      end
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) g = ~g;
      t = ($urandom_range(0, 3) != 0);
      do_tick(t ? g : 1'($urandom_range(0, 1)), t);
      tests++;
      if (out !== 16'(m_lvl) || stage !== 3'(m_st) || busy !== (m_st != 0)) begin
        fails++;
        $display("FAIL random[%0d] got out=%h stage=%0d busy=%b want out=%h stage=%0d busy=%b",
                 i, out, stage, busy, 16'(m_lvl), m_st, m_st != 0);
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_adsr_ramp();
    test_hold();
    test_zero_attack();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adsr.md
ADSR -- requirements
Module: adsr

Interface
REQ-001 SHALL have parameter TOTAL_BITS, default 16, total width of every level/rate value.
REQ-002 SHALL have parameter FRACTIONAL_BITS, default 8, fractional bits; values are unsigned fixed-point U(TOTAL_BITS-FRACTIONAL_BITS, FRACTIONAL_BITS).
REQ-003 SHALL have port clk input 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset input 1, asynchronous active-high reset.
REQ-005 SHALL have port sample_tick input 1, one-cycle strobe; the envelope advances only on cycles where it is high.
REQ-006 SHALL have port gate input 1, note on (1) / note off (0), sampled only on sample_tick.
REQ-007 SHALL have port attack_step input TOTAL_BITS, level increment per tick in ATTACK.
REQ-008 SHALL have port decay_step input TOTAL_BITS, level decrement per tick in DECAY.
REQ-009 SHALL have port sustain_level input TOTAL_BITS, hold level in SUSTAIN.
REQ-010 SHALL have port release_step input TOTAL_BITS, level decrement per tick in RELEASE.
REQ-011 SHALL have port out output TOTAL_BITS, registered envelope level, gain operand for the downstream fixed-point multiplier.
REQ-012 SHALL have port stage output 3, current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-013 SHALL have port busy output 1, high whenever stage != IDLE.

Function
REQ-014 ONE = 1<<FRACTIONAL_BITS (unity gain); out SHALL never exceed ONE nor go below 0.
REQ-015 Effective sustain S = min(sustain_level, ONE), evaluated every tick.
REQ-016 On cycles without sample_tick, out, stage and the sampled-gate register SHALL hold.
REQ-017 Updates SHALL be visible on out/stage the clock edge that samples sample_tick=1 (latency 1 cycle).
REQ-018 IDLE: gate=1 -> ATTACK (level step applied the same tick); else hold out=0.
REQ-019 ATTACK: level += attack_step, computed at TOTAL_BITS+1 bits; result >= ONE or attack_step=0 -> out=ONE, go DECAY.
REQ-020 DECAY: level -= decay_step; result <= S, underflow, or decay_step=0 -> out=S, go SUSTAIN.
REQ-021 SUSTAIN: out tracks S each tick; state held while gate=1.
REQ-022 In ATTACK, DECAY or SUSTAIN, gate=0 on a tick -> RELEASE; gate priority over level-step transitions; first decrement applied same tick.
REQ-023 RELEASE: level -= release_step; result underflows/equals 0 or release_step=0 -> out=0, go IDLE.
REQ-024 RELEASE with gate=1 on a tick (retrigger) -> ATTACK, starting level per REQ-031/032.
REQ-025 Gate pulses wholly between ticks SHALL be ignored.
REQ-026 stage encodings 5..7 SHALL be unreachable; if entered, next tick -> IDLE with out=0.

Reset
REQ-027 reset high SHALL immediately (asynchronously) force out=0, stage=IDLE, busy=0, sampled gate=0.
REQ-028 Reset mid-envelope SHALL discard all progress; after deassertion, first tick with gate=1 enters ATTACK from 0.
REQ-029 Reset deassertion SHALL be honoured on the next clk edge; no tick required to leave reset.

Configuration
REQ-030 Macro ADSR_HARD_RETRIGGER_EN SHALL select retrigger behaviour.
REQ-031 Defined: entering ATTACK from RELEASE first sets level to 0, then adds attack_step on that tick.
REQ-032 Undefined: entering ATTACK from RELEASE continues from the current level (legato, no click).

Verification (TOTAL_BITS=16, FRACTIONAL_BITS=8, ONE=0x0100)
REQ-033 attack_step=0x0040, decay_step=0x0020, sustain=0x0080, gate=1, tick every cycle -> out 0x40,0x80,0xC0,0x100 (DECAY), 0xE0,0xC0,0xA0,0x80 (SUSTAIN), busy=1.
REQ-034 From SUSTAIN at 0x0080, gate=0, release_step=0x0030 -> out 0x50,0x20,0x00, stage IDLE, busy=0 on the 0x00 tick.
REQ-035 attack_step=0x0000 -> out=0x0100 on first tick; sustain_level=0x0200 -> SUSTAIN holds 0x0100.
REQ-036 Retrigger at RELEASE level 0x0050, attack_step=0x0040 -> out 0x0090 without macro, 0x0040 with ADSR_HARD_RETRIGGER_EN.
REQ-037 Assert reset mid-ATTACK (out=0x0080) between clk edges -> out=0, stage=0 immediately; sample_tick low for 10 cycles with gate=1 -> out stays 0x0000.
